coin_sprite_scheduler: RTL and testbench
========================================

Name: coin_sprite_scheduler

Overview:
- Shares one coin sprite-sheet ROM (13-bit address, 256-wide sheet, 2-bit palette index) among NUM_COINS on-screen coin objects.
- Per pixel, it resolves which coin (if any) covers DrawX/DrawY, then forms the ROM address from the coin-local offset and the current animation frame.
- Holds per-coin position and active registers, double-buffered so that updates take effect only at frame boundaries.
- Sits between the game-logic register writer and the shared coin ROM/palette path in the VGA pixel pipeline.

Parameters:
- NUM_COINS, 4, number of coin objects sharing the ROM (1..8)
- SPR_W, 32, sprite frame width in pixels
- SPR_H, 32, sprite frame height in pixels
- SHEET_W, 256, ROM row pitch in pixels; frames are laid out horizontally
- NUM_FRAMES, 8, animation frames in the sheet (NUM_FRAMES*SPR_W <= SHEET_W)
- FRAME_DIV, 6, video frames per animation step (>=1)
- V_ACTIVE, 480, first non-visible line; the latch point

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- wr_en  in  1  single-cycle config write strobe
- wr_idx  in  3  coin index being written
- wr_x  in  10  coin top-left x
- wr_y  in  10  coin top-left y
- wr_active  in  1  coin visible flag
- anim_en  in  1  1 = animation runs, 0 = frame counter frozen
- rom_address  out  13  address to the shared ROM
- hit  out  1  current pixel is covered by an active coin
- hit_idx  out  3  index of the covering coin
- frame_tick  out  1  one-cycle pulse at each latch point
- anim_frame  out  3  current animation frame

Behaviour:
- Reset (async, reset_n=0):
  - All pending and active registers clear: x=0, y=0, active=0.
  - anim_frame=0 and div counter=0.
  - rom_address=0, hit=0, hit_idx=0, frame_tick=0.
- Config write:
  - When wr_en=1, write x/y/active into the pending set at wr_idx on the vga_clk posedge.
  - A write with wr_idx >= NUM_COINS is ignored.
  - The last write to an index within a frame wins.
- Latch point: the cycle where DrawX==0 and DrawY==V_ACTIVE.
  - Copy the whole pending set into the active set.
  - Pulse frame_tick for one cycle.
  - A write in the same cycle lands in pending only and becomes visible at the next latch point.
- Animation counter (states RUN and HOLD, selected by anim_en):
  - RUN: at each latch point the div counter increments. When it reaches FRAME_DIV-1 it resets to 0 and anim_frame increments, wrapping from NUM_FRAMES-1 to 0.
  - HOLD: anim_frame and the div counter are frozen.
  - anim_en is sampled only at latch points, so no mid-frame frame change is possible.
- Hit test (combinational; uses the active set only):
  - Coin i covers the pixel when active=1, x_i <= DrawX < x_i+SPR_W and y_i <= DrawY < y_i+SPR_H.
  - Compare in 11-bit unsigned arithmetic so that x_i+SPR_W does not wrap. A coin at the right or bottom edge is clipped, never wrapped to 0.
  - Lowest index wins on overlap.
- Address: lx=DrawX-x_i, ly=DrawY-y_i, rom_address = ly*SHEET_W + anim_frame*SPR_W + lx, truncated to 13 bits.
- Output timing:
  - rom_address, hit and hit_idx are registered on vga_clk posedge, giving 1-cycle latency from DrawX/DrawY.
  - The ROM reads on the negedge and the pixel is registered on the next posedge.
  - When hit=0: rom_address=0 and hit_idx=0.
- Reset deasserted mid-line: outputs are valid from the first posedge after release. The active set stays empty until the first latch point.

Optional Feature:
- COIN_SCHED_BLINK_EN defined:
  - Adds per-coin input bit wr_blink, stored with pending/active.
  - An internal blink phase toggles every 16 latch points.
  - A coin with blink=1 is treated as inactive while the phase is 1.
  - Reset clears the phase to 0.
- Undefined: no wr_blink port; coins are never hidden by blink.

Decomposition:
- Package coin_sched_pkg:
  - coin_t struct {x[9:0], y[9:0], active, blink}
  - constants SPR_W, SPR_H, SHEET_W, NUM_FRAMES
  - index width localparam
- One sub-module, coin_hit_resolver (combinational): takes the active array and DrawX/DrawY; returns hit, idx, lx, ly.
- Registers and the animation counter stay in the top module.

Test Plan:
- Reset then no writes: sweep a frame -> hit=0 everywhere, rom_address=0, anim_frame=0.
- Write coin0 (100,50,active), wait for latch, anim_en=0: DrawX=105, DrawY=60 -> next cycle hit=1, idx=0, rom_address=10*256+5=2565. DrawX=132 -> hit=0.
- Coin0 (100,50) and coin1 (110,55) both active: pixel (115,60) -> idx=0. Deactivate coin0 mid-frame -> still idx=0 until the latch point, then idx=1 with rom_address=5*256+5=1285.
- anim_en=1, FRAME_DIV=6: after 6 latch points anim_frame=1; after 48 it wraps to 0. Pixel (100,50) with frame 3 -> rom_address=96.
- Coin at (620,470): pixel (639,479) -> hit, rom_address=9*256+19=2323. Next line start (0,0) -> no wrap hit.
- Assert reset_n low mid-line with coins active -> outputs clear asynchronously; after release hit=0 until the first latch following new writes. With COIN_SCHED_BLINK_EN: a blink coin is visible for 16 frames, then hidden for 16.

Source files
------------

// File: rtl/coin_sched_pkg.sv
// Shared types and sprite-sheet geometry for the coin sprite scheduler.
package coin_sched_pkg;

  localparam int SPR_W      = 32;
  localparam int SPR_H      = 32;
  localparam int SHEET_W    = 256;
  localparam int NUM_FRAMES = 8;
  localparam int IDX_W      = 3;
  localparam int ADDR_W     = 13;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       blink;
  } coin_t;

  localparam int COIN_W = $bits(coin_t);

  typedef enum logic {
    ANIM_HOLD = 1'b0,
    ANIM_RUN  = 1'b1
  } anim_state_e;

  // Row-major sheet: frames sit side by side, so the frame selects a column band.
  function automatic logic [ADDR_W-1:0] sprite_addr(input logic [9:0] lx,
                                                    input logic [9:0] ly,
                                                    input logic [2:0] frame);
    return ADDR_W'(ly) * ADDR_W'(SHEET_W) + ADDR_W'(frame) * ADDR_W'(SPR_W) + ADDR_W'(lx);
  endfunction

endpackage

// File: rtl/coin_hit_resolver.sv
// Combinational per-pixel coverage test over the active coin set; lowest index wins.
module coin_hit_resolver
  import coin_sched_pkg::*;
#(
  parameter int NUM_COINS = 4
) (
  input  logic [NUM_COINS*COIN_W-1:0] coins_i,
  input  logic                        blink_phase_i,
  input  logic [9:0]                  draw_x_i,
  input  logic [9:0]                  draw_y_i,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            idx_o,
  output logic [9:0]                  lx_o,
  output logic [9:0]                  ly_o
);

  coin_t      c;
  logic       visible;
  logic       in_x;
  logic       in_y;

  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    lx_o    = '0;
    ly_o    = '0;
    c       = '0;
    visible = 1'b0;
    in_x    = 1'b0;
    in_y    = 1'b0;
    // Walk from the top index down so the lowest covering index is the last writer.
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      c       = coin_t'(coins_i[i*COIN_W +: COIN_W]);
      visible = c.active & ~(c.blink & blink_phase_i);
      in_x    = ({1'b0, draw_x_i} >= {1'b0, c.x}) &&
                ({1'b0, draw_x_i} <  ({1'b0, c.x} + 11'(SPR_W)));
      in_y    = ({1'b0, draw_y_i} >= {1'b0, c.y}) &&
                ({1'b0, draw_y_i} <  ({1'b0, c.y} + 11'(SPR_H)));
      if (visible && in_x && in_y) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
        lx_o  = draw_x_i - c.x;
        ly_o  = draw_y_i - c.y;
      end
    end
  end

endmodule

// File: rtl/coin_sprite_scheduler.sv
// Shares one coin sprite ROM among NUM_COINS objects with frame-synchronous config latching.
// Optional per-coin blinking is enabled by defining COIN_SCHED_BLINK_EN.
//
// state     | meaning
// ANIM_HOLD | anim_en was 0 at the last latch point; frame and divider frozen
// ANIM_RUN  | anim_en was 1 at the last latch point; divider advanced there
module coin_sprite_scheduler
  import coin_sched_pkg::*;
#(
  parameter int NUM_COINS = 4,
  parameter int FRAME_DIV = 6,
  parameter int V_ACTIVE  = 480
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic        wr_active,
`ifdef COIN_SCHED_BLINK_EN
  input  logic        wr_blink,
`endif
  input  logic        anim_en,
  output logic [12:0] rom_address,
  output logic        hit,
  output logic [2:0]  hit_idx,
  output logic        frame_tick,
  output logic [2:0]  anim_frame
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  coin_t [NUM_COINS-1:0] pend_q, pend_d;
  coin_t [NUM_COINS-1:0] act_q, act_d;

  anim_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       frame_q, frame_d;
  logic             tick_q;

  logic [ADDR_W-1:0] rom_q, rom_d;
  logic              hit_q;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic             latch;
  logic             wr_blink_s;
  logic             blink_phase;
  logic             r_hit;
  logic [IDX_W-1:0] r_idx;
  logic [9:0]       r_lx;
  logic [9:0]       r_ly;

  assign latch = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

`ifdef COIN_SCHED_BLINK_EN
  logic [3:0] bcnt_q, bcnt_d;
  logic       phase_q, phase_d;

  assign wr_blink_s  = wr_blink;
  assign blink_phase = phase_q;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (latch) begin
      bcnt_d = bcnt_q + 4'd1;
      if (bcnt_q == 4'd15) phase_d = ~phase_q;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  assign wr_blink_s  = 1'b0;
  assign blink_phase = 1'b0;
`endif

  // Latch copies the pre-edge pending set, so a same-cycle write waits a frame.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (latch) act_d = pend_q;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (wr_en && (wr_idx == 3'(i))) begin
        pend_d[i].x      = wr_x;
        pend_d[i].y      = wr_y;
        pend_d[i].active = wr_active;
        pend_d[i].blink  = wr_blink_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    frame_d = frame_q;
    if (latch) state_d = anim_en ? ANIM_RUN : ANIM_HOLD;
    if (latch && (state_d == ANIM_RUN)) begin
      if (div_q == DIV_W'(FRAME_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  coin_hit_resolver #(
    .NUM_COINS(NUM_COINS)
  ) u_resolver (
    .coins_i      (act_q),
    .blink_phase_i(blink_phase),
    .draw_x_i     (DrawX),
    .draw_y_i     (DrawY),
    .hit_o        (r_hit),
    .idx_o        (r_idx),
    .lx_o         (r_lx),
    .ly_o         (r_ly)
  );

  always_comb begin
    rom_d = '0;
    idx_d = '0;
    if (r_hit) begin
      rom_d = sprite_addr(r_lx, r_ly, frame_q);
      idx_d = r_idx;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= '0;
      act_q   <= '0;
      state_q <= ANIM_HOLD;
      div_q   <= '0;
      frame_q <= '0;
      tick_q  <= 1'b0;
      rom_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      state_q <= state_d;
      div_q   <= div_d;
      frame_q <= frame_d;
      tick_q  <= latch;
      rom_q   <= rom_d;
      hit_q   <= r_hit;
      idx_q   <= idx_d;
    end
  end

  assign rom_address = rom_q;
  assign hit         = hit_q;
  assign hit_idx     = idx_q;
  assign frame_tick  = tick_q;
  assign anim_frame  = frame_q;

endmodule

// File: tb/tb_coin_sprite_scheduler.sv
// Randomized and directed bench for coin_sprite_scheduler against a pixel-level reference model.
module tb_coin_sprite_scheduler;

  localparam int NC = 4;
  localparam int FD = 6;
  localparam int VA = 480;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [9:0]  wr_x, wr_y;
  logic        wr_active;
  logic        wr_blink;
  logic        anim_en;
  logic [12:0] rom_address;
  logic        hit;
  logic [2:0]  hit_idx;
  logic        frame_tick;
  logic [2:0]  anim_frame;

  always #5 vga_clk = ~vga_clk;

  coin_sprite_scheduler #(
    .NUM_COINS(NC),
    .FRAME_DIV(FD),
    .V_ACTIVE (VA)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_active  (wr_active),
`ifdef COIN_SCHED_BLINK_EN
    .wr_blink   (wr_blink),
`endif
    .anim_en    (anim_en),
    .rom_address(rom_address),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .frame_tick (frame_tick),
    .anim_frame (anim_frame)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: pending/active coin sets and animation state as plain integers.
  int px[8], py[8], ax[8], ay[8];
  bit pa[8], pb[8], aa[8], ab[8];
  int mframe, mdiv, mbcnt;
  bit mphase;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      px[i] = 0; py[i] = 0; pa[i] = 0; pb[i] = 0;
      ax[i] = 0; ay[i] = 0; aa[i] = 0; ab[i] = 0;
    end
    mframe = 0; mdiv = 0; mbcnt = 0; mphase = 0;
  endtask

  function automatic void expect_pix(input int x, input int y,
                                     output bit h, output int idx, output int addr);
    h = 0; idx = 0; addr = 0;
    for (int i = 0; i < NC; i++) begin
      if (!h && aa[i] && !(ab[i] && mphase) &&
          x >= ax[i] && x < ax[i] + 32 && y >= ay[i] && y < ay[i] + 32) begin
        h    = 1;
        idx  = i;
        addr = ((y - ay[i]) * 256 + mframe * 32 + (x - ax[i])) % 8192;
      end
    end
  endfunction

  task automatic cyc(input int x, input int y, input bit wen, input int widx,
                     input int wx, input int wy, input bit wact, input bit wbl);
    bit eh;
    int ei, ea;
    bit lat;
    @(negedge vga_clk);
    DrawX = x[9:0]; DrawY = y[9:0];
    wr_en = wen; wr_idx = widx[2:0]; wr_x = wx[9:0]; wr_y = wy[9:0];
    wr_active = wact; wr_blink = wbl;
    expect_pix(x, y, eh, ei, ea);
    lat = (x == 0) && (y == VA);
    if (lat) begin
      for (int i = 0; i < 8; i++) begin
        ax[i] = px[i]; ay[i] = py[i]; aa[i] = pa[i]; ab[i] = pb[i];
      end
      if (anim_en) begin
        mdiv++;
        if (mdiv == FD) begin
          mdiv = 0;
          mframe = (mframe + 1) % 8;
        end
      end
      mbcnt = (mbcnt + 1) % 16;
      if (mbcnt == 0) mphase = !mphase;
    end
    if (wen && widx < NC) begin
      px[widx] = wx; py[widx] = wy; pa[widx] = wact;
`ifdef COIN_SCHED_BLINK_EN
      pb[widx] = wbl;
`else
      pb[widx] = 0;
`endif
    end
    @(posedge vga_clk);
    #1;
    chk("hit", 32'(hit), 32'(eh));
    chk("hit_idx", 32'(hit_idx), 32'(ei));
    chk("rom_address", 32'(rom_address), 32'(ea));
    chk("frame_tick", 32'(frame_tick), 32'(lat));
    chk("anim_frame", 32'(anim_frame), 32'(mframe));
    wr_en = 1'b0;
  endtask

  task automatic step(input int x, input int y);
    cyc(x, y, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wstep(input int x, input int y, input int widx, input int wx,
                       input int wy, input bit wact, input bit wbl);
    cyc(x, y, 1, widx, wx, wy, wact, wbl);
  endtask

  task automatic latch_pt();
    step(0, VA);
  endtask

  initial begin
    int k, x, y, vis;
    reset_n = 1'b0; DrawX = '0; DrawY = '0; wr_en = 1'b0; wr_idx = '0;
    wr_x = '0; wr_y = '0; wr_active = 1'b0; wr_blink = 1'b0; anim_en = 1'b0;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_hit", 32'(hit), 0);
    chk("rst_idx", 32'(hit_idx), 0);
    chk("rst_addr", 32'(rom_address), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_frame", 32'(anim_frame), 0);
    @(negedge vga_clk);
    reset_n = 1'b1;

    for (int n = 0; n < 8; n++) step($urandom_range(0, 639), $urandom_range(0, 479));
    latch_pt();

    // Single coin and right-edge boundary
    wstep(5, 5, 0, 100, 50, 1, 0);
    step(105, 60);
    chk("pre_latch_no_hit", 32'(hit), 0);
    latch_pt();
    step(105, 60);
    chk("c0_addr", 32'(rom_address), 2565);
    chk("c0_idx", 32'(hit_idx), 0);
    step(132, 60);
    chk("c0_right_out", 32'(hit), 0);
    step(131, 81);
    chk("c0_last_pix", 32'(rom_address), 31 * 256 + 31);

    // Overlap priority and mid-frame deactivate
    wstep(5, 5, 1, 110, 55, 1, 0);
    latch_pt();
    step(115, 60);
    chk("ovl_idx0", 32'(hit_idx), 0);
    wstep(115, 60, 0, 100, 50, 0, 0);
    step(115, 60);
    chk("ovl_still0", 32'(hit_idx), 0);
    latch_pt();
    step(115, 60);
    chk("ovl_idx1", 32'(hit_idx), 1);
    chk("ovl_addr1", 32'(rom_address), 1285);

    // Bottom-right clipping, ignored out-of-range index
    wstep(5, 5, 1, 110, 55, 0, 0);
    wstep(5, 5, 2, 620, 470, 1, 0);
    wstep(5, 5, 5, 600, 460, 1, 0);
    latch_pt();
    step(639, 479);
    chk("edge_hit", 32'(hit), 1);
    chk("edge_addr", 32'(rom_address), 2323);
    step(0, 0);
    chk("edge_nowrap", 32'(hit), 0);
    step(610, 465);
    chk("idx5_ignored", 32'(hit), 0);

    // Animation run, wrap, hold
    wstep(5, 5, 0, 100, 50, 1, 0);
    anim_en = 1'b1;
    for (int n = 0; n < 6; n++) latch_pt();
    chk("anim_6", 32'(anim_frame), 1);
    for (int n = 0; n < 42; n++) latch_pt();
    chk("anim_48", 32'(anim_frame), 0);
    for (int n = 0; n < 18; n++) latch_pt();
    anim_en = 1'b0;
    step(100, 50);
    chk("anim_f3_addr", 32'(rom_address), 96);
    for (int n = 0; n < 7; n++) latch_pt();
    chk("anim_hold", 32'(anim_frame), 3);

`ifdef COIN_SCHED_BLINK_EN
    wstep(5, 5, 3, 300, 300, 1, 1);
    latch_pt();
    vis = 0;
    for (int n = 0; n < 32; n++) begin
      step(305, 305);
      if (hit) vis++;
      latch_pt();
    end
    chk("blink_visible", 32'(vis), 16);
    wstep(5, 5, 3, 300, 300, 0, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) anim_en = ~anim_en;
      k = $urandom_range(0, 15);
      if (k == 0) begin
        if ($urandom_range(0, 3) == 0)
          wstep(0, VA, $urandom_range(0, 7), $urandom_range(0, 1023),
                $urandom_range(0, 1023), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else
          latch_pt();
      end else if (k < 4) begin
        wstep($urandom_range(0, 1023), $urandom_range(0, 479), $urandom_range(0, 7),
              $urandom_range(0, 660), $urandom_range(0, 500),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end else begin
        k = $urandom_range(0, NC - 1);
        x = (ax[k] + $urandom_range(0, 40) - 4) & 1023;
        y = (ay[k] + $urandom_range(0, 40) - 4) & 1023;
        step(x, y);
      end
    end

    // Asynchronous reset mid-line with a visible coin
    anim_en = 1'b0;
    wstep(5, 5, 0, 100, 50, 1, 0);
    latch_pt();
    step(105, 60);
    chk("pre_rst_hit", 32'(hit), 1);
    @(negedge vga_clk);
    DrawX = 10'd105; DrawY = 10'd60;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_hit", 32'(hit), 0);
    chk("arst_addr", 32'(rom_address), 0);
    chk("arst_idx", 32'(hit_idx), 0);
    chk("arst_frame", 32'(anim_frame), 0);
    model_reset();
    @(posedge vga_clk);
    #3 reset_n = 1'b1;
    step(105, 60);
    chk("post_rst_hit", 32'(hit), 0);
    latch_pt();
    step(105, 60);
    chk("post_rst_empty", 32'(hit), 0);
    wstep(5, 5, 0, 100, 50, 1, 0);
    latch_pt();
    step(105, 60);
    chk("post_rst_rewrite", 32'(rom_address), 2565);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
